// File: rtl/decode_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// decode_hazard_scoreboard
// In-flight destination tracker: forwarding selects, producer types, load-use stall.
// Revision: 1.0
// ============================================================================
module decode_hazard_scoreboard #(
  parameter int STAGES      = 4,
  parameter int RA_W        = 5,
  parameter int LOAD_READY  = 2,
  parameter int FLUSH_DEPTH = 1,
  parameter int SEL_W       = $clog2(STAGES + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             HOLD,
  input  logic             FLUSH,
  input  logic             ID_VALID,
  input  logic [RA_W-1:0]  RS1_SEL,
  input  logic [RA_W-1:0]  RS2_SEL,
  input  logic             RS1_USED,
  input  logic             RS2_USED,
  input  logic [RA_W-1:0]  RD_IN,
  input  logic [1:0]       TYPE_IN,
  output logic [SEL_W-1:0] MUX1_SELECT,
  output logic [SEL_W-1:0] MUX2_SELECT,
  output logic [1:0]       RS1_TYPE,
  output logic [1:0]       RS2_TYPE,
  output logic             STALL,
  output logic [SEL_W-1:0] OCC
);

  localparam logic [1:0]       T_IDLE = 2'd0;
  localparam logic [1:0]       T_ALU  = 2'd1;
  localparam logic [1:0]       T_LOAD = 2'd2;
  localparam logic [SEL_W-1:0] LR_SEL = SEL_W'(LOAD_READY);

  logic [RA_W-1:0]  rd_q [1:STAGES];
  logic [1:0]       ty_q [1:STAGES];
  logic [RA_W-1:0]  rd_d [1:STAGES];
  logic [1:0]       ty_d [1:STAGES];
  logic [SEL_W-1:0] occ_q;
  logic [SEL_W-1:0] occ_d;
  logic             hazard1;
  logic             hazard2;
  logic             accept;
  int               cnt;

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    MUX1_SELECT = '0;
    MUX2_SELECT = '0;
    RS1_TYPE    = T_IDLE;
    RS2_TYPE    = T_IDLE;
    for (int k = STAGES; k >= 1; k--) begin
      if ((ty_q[k] == T_ALU) || (ty_q[k] == T_LOAD)) begin
        if (RS1_USED && (RS1_SEL != '0) && (rd_q[k] == RS1_SEL)) begin
          MUX1_SELECT = SEL_W'(k);
          RS1_TYPE    = ty_q[k];
        end
        if (RS2_USED && (RS2_SEL != '0) && (rd_q[k] == RS2_SEL)) begin
          MUX2_SELECT = SEL_W'(k);
          RS2_TYPE    = ty_q[k];
        end
      end
    end
  end

  assign hazard1 = (RS1_TYPE == T_LOAD) && (MUX1_SELECT < LR_SEL);
  assign hazard2 = (RS2_TYPE == T_LOAD) && (MUX2_SELECT < LR_SEL);
  assign STALL   = ID_VALID && !FLUSH && (hazard1 || hazard2);
  assign accept  = ID_VALID && !STALL && !FLUSH &&
                   ((TYPE_IN == T_ALU) || (TYPE_IN == T_LOAD));

  always_comb begin
    for (int k = 1; k <= STAGES; k++) begin
      rd_d[k] = rd_q[k];
      ty_d[k] = ty_q[k];
    end
    if (HOLD) begin
      // Frozen pipe: a redirect can still kill the youngest entries in place.
      for (int k = 1; k <= STAGES; k++) begin
        if (FLUSH && (k <= FLUSH_DEPTH)) begin
          rd_d[k] = '0;
          ty_d[k] = T_IDLE;
        end
      end
    end else begin
      for (int k = 2; k <= STAGES; k++) begin
        rd_d[k] = rd_q[k-1];
        ty_d[k] = ty_q[k-1];
      end
      rd_d[1] = accept ? RD_IN   : '0;
      ty_d[1] = accept ? TYPE_IN : T_IDLE;
      for (int k = 2; k <= STAGES; k++) begin
        if (FLUSH && (k <= FLUSH_DEPTH)) begin
          rd_d[k] = '0;
          ty_d[k] = T_IDLE;
        end
      end
    end
    cnt = 0;
    for (int k = 1; k <= STAGES; k++) begin
      if (ty_d[k] != T_IDLE) cnt = cnt + 1;
    end
    occ_d = SEL_W'(cnt);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 1; k <= STAGES; k++) begin
        rd_q[k] <= '0;
        ty_q[k] <= T_IDLE;
      end
      occ_q <= '0;
    end else begin
      for (int k = 1; k <= STAGES; k++) begin
        rd_q[k] <= rd_d[k];
        ty_q[k] <= ty_d[k];
      end
      occ_q <= occ_d;
    end
  end

  assign OCC = occ_q;

endmodule
`default_nettype wire
